// File: rtl/analyzer_capture_ctrl_if.sv
// Host/probe-side signal bundle for the capture controller.
// master = host/probe driver, slave = analyzer_capture_ctrl.
interface analyzer_capture_ctrl_if #(
  parameter int WAVE_ADDR_WIDTH = 12,
  parameter int DIGITAL_IN_NUM  = 8,
  parameter int DIV_WIDTH       = 16
);
  logic [DIGITAL_IN_NUM-1:0]  digital_in;
  logic                       arm;
  logic                       abort;
  logic                       ext_trig;
  logic [DIGITAL_IN_NUM-1:0]  trig_mask;
  logic [DIGITAL_IN_NUM-1:0]  trig_pattern;
  logic [WAVE_ADDR_WIDTH-1:0] pre_cnt;
  logic [DIV_WIDTH-1:0]       clk_div;
  logic                       busy;
  logic                       triggered;
  logic                       done;
  logic [WAVE_ADDR_WIDTH-1:0] wave_addr;
  logic [31:0]                wave_out;

  modport master (
    output digital_in, arm, abort, ext_trig, trig_mask, trig_pattern,
           pre_cnt, clk_div, wave_addr,
    input  busy, triggered, done, wave_out
  );

  modport slave (
    input  digital_in, arm, abort, ext_trig, trig_mask, trig_pattern,
           pre_cnt, clk_div, wave_addr,
    output busy, triggered, done, wave_out
  );
endinterface

// File: rtl/analyzer_capture_ctrl.sv
// Logic-analyser capture controller: circular pre-trigger buffer, sample-rate
// divider, masked pattern / external trigger and linearised readback.
module analyzer_capture_ctrl #(
  parameter int WAVE_ADDR_WIDTH = 12,
  parameter int DIGITAL_IN_NUM  = 8,
  parameter int DIV_WIDTH       = 16
) (
  input logic                    clk,
  input logic                    rst,
  analyzer_capture_ctrl_if.slave bus
);
  localparam int AW    = WAVE_ADDR_WIDTH;
  localparam int DN    = DIGITAL_IN_NUM;
  localparam int DV    = DIV_WIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ONE_P   = (AW+1)'(1);
  localparam logic [DV-1:0] ONE_D   = DV'(1);
  localparam logic [AW:0]   DEPTH_P = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DN-1:0] mask_l, pattern_l;
  logic [AW-1:0] pre_l;
  logic [DV-1:0] div_l;
  logic [DV-1:0] div_cnt;
  logic [AW-1:0] wr_ptr, start_ptr;
  logic [AW-1:0] pre_seen;
  logic [AW:0]   post_cnt;
  logic [AW:0]   post_target;
  logic          busy_st, arm_ok, strobe, hit, we, trig_fire;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;
  logic [DN-1:0] ram_q;
  logic [31:0]   wave_w;

  logic [DN-1:0] mem [DEPTH];

  assign busy_st     = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign arm_ok      = bus.arm && !bus.abort && ((state == S_IDLE) || (state == S_DONE));
  assign strobe      = busy_st && (div_cnt == div_l);
  assign hit         = bus.ext_trig || ((bus.digital_in & mask_l) == (pattern_l & mask_l));
  assign we          = strobe && !bus.abort;
  // Samples still to store after the trigger, trigger sample included.
  assign post_target = DEPTH_P - {1'b0, pre_l};
  assign rd_addr     = start_ptr + bus.wave_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig_fire = 1'b0;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.arm) state_nxt = (bus.pre_cnt != '0) ? S_PRE : S_WAIT;
        end
        S_PRE: begin
          if (strobe && (pre_seen == pre_l - ONE_A)) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (strobe && hit) begin
            trig_fire = 1'b1;
            state_nxt = (post_target == ONE_P) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (strobe && (post_cnt + ONE_P == post_target)) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_st;
  assign bus.triggered = (state == S_POST) || (state == S_DONE);
  assign bus.done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_l    <= '0;
      pattern_l <= '0;
      pre_l     <= '0;
      div_l     <= '0;
      div_cnt   <= '0;
      wr_ptr    <= '0;
      start_ptr <= '0;
      pre_seen  <= '0;
      post_cnt  <= '0;
      rd_ok     <= 1'b0;
    end else begin
      rd_ok <= 1'b1;
      // wr_ptr keeps running across captures; readback is rebased on start_ptr.
      if (we) wr_ptr <= wr_ptr + ONE_A;
      if (bus.abort) begin
        div_cnt  <= '0;
        pre_seen <= '0;
        post_cnt <= '0;
      end else if (arm_ok) begin
        mask_l    <= bus.trig_mask;
        pattern_l <= bus.trig_pattern;
        pre_l     <= bus.pre_cnt;
        div_l     <= bus.clk_div;
        div_cnt   <= '0;
        pre_seen  <= '0;
        post_cnt  <= '0;
      end else if (busy_st) begin
        div_cnt <= strobe ? '0 : div_cnt + ONE_D;
        if (strobe && (state == S_PRE)) pre_seen <= pre_seen + ONE_A;
        if (trig_fire) begin
          start_ptr <= wr_ptr - pre_l;
          post_cnt  <= ONE_P;
        end else if (strobe && (state == S_POST)) begin
          post_cnt <= post_cnt + ONE_P;
        end
      end
    end
  end

  // Plain dual-port RAM; read of a location being written returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= bus.digital_in;
    ram_q <= mem[rd_addr];
  end

  // rd_ok masks the unreset RAM output so wave_out reads 0 straight out of reset.
  always_comb begin
    wave_w = '0;
    if (rd_ok) wave_w[DN-1:0] = ram_q;
  end

  assign bus.wave_out = wave_w;

endmodule
